// File: rtl/alu_mem_sequencer.sv
// Sequencer that reads two operands from memory, runs them through an external
// combinational ALU and writes the result back, with fixed latency per opcode.
module alu_mem_sequencer #(
  parameter int WORDSIZE   = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] src_a,
  input  logic [ADDR_WIDTH-1:0] src_b,
  input  logic [ADDR_WIDTH-1:0] dst,
  output logic                  busy,
  output logic                  done,
  output logic [WORDSIZE-1:0]   result,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WORDSIZE-1:0]   mem_data_in,
  output logic                  mem_WE,
  output logic                  mem_RE,
  output logic                  mem_Enable,
  input  logic [WORDSIZE-1:0]   mem_data_out,
  output logic [WORDSIZE-1:0]   alu_ain,
  output logic [WORDSIZE-1:0]   alu_bin,
  output logic [3:0]            alu_ctrl,
  input  logic [WORDSIZE-1:0]   alu_zout,
  input  logic                  alu_overflow
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_A  = 3'd1;
  localparam logic [2:0] S_RD_B  = 3'd2;
  localparam logic [2:0] S_CAP_B = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_WR    = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]            r_state;
  logic [2:0]            w_next_state;
  logic [3:0]            r_opcode;
  logic [ADDR_WIDTH-1:0] r_src_a;
  logic [ADDR_WIDTH-1:0] r_src_b;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [WORDSIZE-1:0]   r_a;
  logic [WORDSIZE-1:0]   r_b;
  logic [WORDSIZE-1:0]   r_result;
  logic                  r_overflow;
  logic                  w_is_nop;

  assign w_is_nop = (r_opcode[3:2] == 2'b11);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RD_A;
      S_RD_A:  w_next_state = S_RD_B;
      S_RD_B:  w_next_state = S_CAP_B;
      S_CAP_B: w_next_state = S_EXEC;
      S_EXEC:  w_next_state = w_is_nop ? S_DONE : S_WR;
      S_WR:    w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register sees
  // the pre-edge value of every other register, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_opcode   <= '0;
      r_src_a    <= '0;
      r_src_b    <= '0;
      r_dst      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opcode <= opcode;
            r_src_a  <= src_a;
            r_src_b  <= src_b;
            r_dst    <= dst;
          end
        end
        S_RD_B:  r_a <= mem_data_out;
        S_CAP_B: r_b <= mem_data_out;
        S_EXEC: begin
          r_result   <= alu_zout;
          r_overflow <= alu_overflow;
        end
        default: ;
      endcase
    end
  end

  // Memory strobes are masked by rst so a reset coinciding with the WR edge
  // cannot commit the write.
  always_comb begin
    mem_Enable  = 1'b0;
    mem_RE      = 1'b0;
    mem_WE      = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    case (r_state)
      S_RD_A: begin
        mem_Enable  = ~rst;
        mem_RE      = ~rst;
        mem_address = r_src_a;
      end
      S_RD_B: begin
        mem_Enable  = ~rst;
        mem_RE      = ~rst;
        mem_address = r_src_b;
      end
      S_WR: begin
        mem_Enable  = ~rst;
        mem_WE      = ~rst;
        mem_address = r_dst;
        mem_data_in = r_result;
      end
      default: ;
    endcase
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign result   = r_result;
  assign overflow = r_overflow;
  assign alu_ain  = r_a;
  assign alu_bin  = r_b;
  assign alu_ctrl = r_opcode;

endmodule

// File: tb/tb_alu_mem_sequencer.sv
// Directed bench for alu_mem_sequencer with a behavioural 512x8 memory and ALU.
module tb_alu_mem_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] opcode;
  logic [8:0] src_a, src_b, dst;
  logic       busy, done, overflow;
  logic [7:0] result;
  logic [8:0] mem_address;
  logic [7:0] mem_data_in, mem_data_out;
  logic       mem_WE, mem_RE, mem_Enable;
  logic [7:0] alu_ain, alu_bin, alu_zout;
  logic [3:0] alu_ctrl;
  logic       alu_overflow;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  logic [7:0] mem [512];
  logic       pl_en = 1'b0;
  logic [8:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  always #5 clk = ~clk;

  alu_mem_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .dst(dst),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_WE(mem_WE), .mem_RE(mem_RE), .mem_Enable(mem_Enable),
    .mem_data_out(mem_data_out),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_ctrl(alu_ctrl),
    .alu_zout(alu_zout), .alu_overflow(alu_overflow)
  );

  // Synchronous memory; read data appears at the edge that samples RE.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_Enable && mem_WE) mem[mem_address] <= mem_data_in;
    if (mem_Enable && mem_RE) mem_data_out <= mem[mem_address];
  end

  // ALU reference; nop opcodes pass operand A through.
  always_comb begin
    logic [8:0] s;
    s            = '0;
    alu_zout     = alu_ain;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      4'd0: begin
        s = {1'b0, alu_ain} + {1'b0, alu_bin};
        alu_zout = s[7:0];
        alu_overflow = (alu_ain[7] == alu_bin[7]) && (alu_zout[7] != alu_ain[7]);
      end
      4'd1: begin
        alu_zout = alu_ain - alu_bin;
        alu_overflow = (alu_ain[7] != alu_bin[7]) && (alu_zout[7] != alu_ain[7]);
      end
      4'd2: begin
        alu_zout = alu_bin - alu_ain;
        alu_overflow = (alu_ain[7] != alu_bin[7]) && (alu_zout[7] != alu_bin[7]);
      end
      4'd3:  alu_zout = alu_ain[3:0] * alu_bin[3:0];
      4'd4:  alu_zout = ~(alu_ain | alu_bin);
      4'd5:  alu_zout = ~alu_ain;
      4'd6:  alu_zout = ~(alu_ain & alu_bin);
      4'd7:  alu_zout = ~(alu_ain ^ alu_bin);
      4'd8:  alu_zout = alu_ain >> 1;
      4'd9:  alu_zout = alu_ain << 1;
      4'd10: alu_zout = {alu_ain[0], alu_ain[7:1]};
      4'd11: alu_zout = {alu_ain[6:0], alu_ain[7]};
      default: alu_zout = alu_ain;
    endcase
  end

  // Per-cycle protocol assertions.
  logic prev_done = 1'b0, prev_busy = 1'b0, prev_rst = 1'b1;
  always @(negedge clk) begin
    if (armed) begin
      assert (!(mem_WE && mem_RE))
        else begin errors++; $display("FAIL we_re_exclusive: WE=%b RE=%b required not both 1", mem_WE, mem_RE); end
      assert (!(done && prev_done))
        else begin errors++; $display("FAIL done_width: done high 2 cycles, required 1"); end
      assert (busy || !prev_busy || prev_done || rst || prev_rst)
        else begin errors++; $display("FAIL busy_drop: busy fell outside DONE->IDLE, required busy=1"); end
      assert (busy || !(done || mem_Enable))
        else begin errors++; $display("FAIL idle_quiet: done=%b en=%b in IDLE, required 0", done, mem_Enable); end
    end
    prev_done <= done;
    prev_busy <= busy;
    prev_rst  <= rst;
  end

  task automatic preload(input logic [8:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] opc, input logic [8:0] a, input logic [8:0] b,
                        input logic [8:0] d, output int done_cyc, output bit we_seen);
    @(posedge clk); #1;
    start = 1'b1; opcode = opc; src_a = a; src_b = b; dst = d;
    @(posedge clk); #1;
    start = 1'b0; opcode = 4'hF; src_a = '1; src_b = '1; dst = '1;
    done_cyc = 0; we_seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_WE) we_seen = 1'b1;
      if (done && done_cyc == 0) done_cyc = k;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; opcode = '0; src_a = '0; src_b = '0; dst = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h want 00", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++;
    if ({mem_Enable, mem_RE, mem_WE, mem_address, mem_data_in} !== '0) begin
      errors++;
      $display("FAIL reset_mem: en=%b re=%b we=%b addr=%h din=%h want all 0",
               mem_Enable, mem_RE, mem_WE, mem_address, mem_data_in);
    end
    checks++;
    if ({alu_ain, alu_bin, alu_ctrl} !== '0) begin
      errors++; $display("FAIL reset_alu: ain=%h bin=%h ctrl=%h want 0", alu_ain, alu_bin, alu_ctrl);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    armed = 1'b1;
  endtask

  task automatic test_rst_priority;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; opcode = 4'd0; src_a = 9'd3; src_b = 9'd4; dst = 9'd10;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_priority: busy=%b want 0", busy); end
  endtask

  task automatic test_add;
    int dc; bit we;
    preload(9'd3, 8'h05);
    preload(9'd4, 8'h03);
    run_op(4'd0, 9'd3, 9'd4, 9'd10, dc, we);
    checks++; if (dc != 6) begin errors++; $display("FAIL add_latency: done cycle %0d want 6", dc); end
    checks++; if (result !== 8'h08) begin errors++; $display("FAIL add_result: got %h want 08", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL add_ovf: got %b want 0", overflow); end
    checks++; if (mem[10] !== 8'h08) begin errors++; $display("FAIL add_mem: mem[10]=%h want 08", mem[10]); end
  endtask

  task automatic test_overflow_alias;
    int dc; bit we;
    preload(9'd1, 8'h7F);
    preload(9'd2, 8'h01);
    run_op(4'd0, 9'd1, 9'd2, 9'd1, dc, we);
    checks++; if (dc != 6) begin errors++; $display("FAIL ovf_latency: done cycle %0d want 6", dc); end
    checks++; if (result !== 8'h80) begin errors++; $display("FAIL ovf_result: got %h want 80", result); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (mem[1] !== 8'h80) begin errors++; $display("FAIL ovf_mem: mem[1]=%h want 80", mem[1]); end
  endtask

  task automatic test_nop;
    int dc; bit we;
    preload(9'd20, 8'hAA);
    preload(9'd21, 8'h5C);
    run_op(4'd13, 9'd21, 9'd3, 9'd20, dc, we);
    checks++; if (dc != 5) begin errors++; $display("FAIL nop_latency: done cycle %0d want 5", dc); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL nop_we: WE seen=%b want 0", we); end
    checks++; if (mem[20] !== 8'hAA) begin errors++; $display("FAIL nop_mem: mem[20]=%h want AA", mem[20]); end
    checks++; if (result !== 8'h5C) begin errors++; $display("FAIL nop_result: got %h want 5C", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL nop_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_sub_and_same_src;
    int dc; bit we;
    preload(9'd5, 8'h10);
    preload(9'd6, 8'h30);
    run_op(4'd1, 9'd5, 9'd6, 9'd12, dc, we);
    checks++; if (result !== 8'hE0) begin errors++; $display("FAIL sub_result: got %h want E0", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sub_ovf: got %b want 0", overflow); end
    checks++; if (mem[12] !== 8'hE0) begin errors++; $display("FAIL sub_mem: mem[12]=%h want E0", mem[12]); end
    run_op(4'd0, 9'd5, 9'd5, 9'd6, dc, we);
    checks++; if (result !== 8'h20) begin errors++; $display("FAIL same_src_result: got %h want 20", result); end
    checks++; if (mem[6] !== 8'h20) begin errors++; $display("FAIL same_src_mem: mem[6]=%h want 20", mem[6]); end
  endtask

  task automatic test_back_to_back;
    int first_d, second_d, n_done;
    first_d = 0; second_d = 0; n_done = 0;
    @(posedge clk); #1;
    start = 1'b1; opcode = 4'd0; src_a = 9'd3; src_b = 9'd4; dst = 9'd10;
    @(posedge clk); #1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_d == 0) first_d = k; else if (second_d == 0) second_d = k;
      end
      if (k == 9) begin #1; start = 1'b0; end
    end
    checks++; if (n_done != 2) begin errors++; $display("FAIL b2b_count: %0d dones want 2", n_done); end
    checks++; if (first_d != 6) begin errors++; $display("FAIL b2b_first: cycle %0d want 6", first_d); end
    checks++; if (second_d != 13) begin errors++; $display("FAIL b2b_second: cycle %0d want 13", second_d); end
  endtask

  task automatic test_rst_in_wr;
    bit saw_done; bit wr_seen;
    saw_done = 1'b0; wr_seen = 1'b0;
    preload(9'd10, 8'h33);
    @(posedge clk); #1;
    start = 1'b1; opcode = 4'd0; src_a = 9'd3; src_b = 9'd4; dst = 9'd10;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) wr_seen = mem_WE;
    end
    checks++; if (wr_seen !== 1'b1) begin errors++; $display("FAIL rstwr_in_wr: WE=%b want 1 in cycle 5", wr_seen); end
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstwr_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstwr_done: got %b want 0", done); end
    checks++;
    if ({mem_Enable, mem_RE, mem_WE, mem_address, mem_data_in} !== '0) begin
      errors++;
      $display("FAIL rstwr_mem: en=%b re=%b we=%b addr=%h din=%h want all 0",
               mem_Enable, mem_RE, mem_WE, mem_address, mem_data_in);
    end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL rstwr_result: got %h want 00", result); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL rstwr_no_done: done pulsed after abort"); end
    checks++; if (mem[10] !== 8'h33) begin errors++; $display("FAIL rstwr_mem10: mem[10]=%h want 33", mem[10]); end
  endtask

  initial begin
    test_reset();
    test_rst_priority();
    test_add();
    test_overflow_alias();
    test_nop();
    test_sub_and_same_src();
    test_back_to_back();
    test_rst_in_wr();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
